// File: rtl/ps2_event_fifo.sv
// PS/2 device-to-host receiver: glitch-filtered deframing, E0/F0 prefix merge into
// single key events {brk, ext, code}, buffered in a first-word-fall-through FIFO.
module ps2_event_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000,
   parameter int KEEP_BREAK  = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            ps2d,
   input  logic                            ps2c,
   input  logic                            rx_en,
   input  logic                            rd_en,
   input  logic                            ovf_clr,
   output logic [9:0]                      dout,
   output logic                            valid,
   output logic                            full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
   output logic                            overflow,
   output logic                            frame_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   logic          c_s1, c_s2, d_s1, d_s2;
   logic          flt_c;
   logic [FW-1:0] flt_cnt;
   logic          fall;

   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par;
   logic [TW-1:0] to_cnt;
   logic          byte_ok;
   logic [7:0]    byte_q;
   logic          err_q;

   logic          ext_f, brk_f;
   logic          push;
   logic [9:0]    push_evt;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, wr_ok, drop;

   // NOTE: every register uses non-blocking assignment so all flops sample the
   // pre-edge values; blocking here would collapse the synchroniser chain to one stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_s1 <= 1'b1;
         c_s2 <= 1'b1;
         d_s1 <= 1'b1;
         d_s2 <= 1'b1;
      end else begin
         c_s1 <= ps2c;
         c_s2 <= c_s1;
         d_s1 <= ps2d;
         d_s2 <= d_s1;
      end
   end

   // Filtered clock flips only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         flt_c   <= 1'b1;
         flt_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (c_s2 == flt_c) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt_c   <= c_s2;
            flt_cnt <= '0;
            fall    <= flt_c;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         to_cnt  <= '0;
         byte_ok <= 1'b0;
         byte_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         byte_ok <= 1'b0;
         err_q   <= 1'b0;
         if (state != S_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state  <= S_IDLE;
            to_cnt <= '0;
            err_q  <= 1'b1;
         end else if (fall) begin
            to_cnt <= '0;
            case (state)
               S_IDLE: begin
                  if (rx_en && !d_s2) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  shreg   <= {d_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= S_PARITY;
               end
               S_PARITY: begin
                  par   <= d_s2;
                  state <= S_STOP;
               end
               default: begin
                  state <= S_IDLE;
                  if ((^{shreg, par}) && d_s2) begin
                     byte_ok <= 1'b1;
                     byte_q  <= shreg;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            endcase
         end else if (state != S_IDLE) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   assign frame_err = err_q;

   // NOTE: every signal driven in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      push     = 1'b0;
      push_evt = {brk_f, ext_f, byte_q};
      if (byte_ok && byte_q != CODE_EXT && byte_q != CODE_BRK)
         push = !brk_f || (KEEP_BREAK != 0);
   end

   always_ff @(posedge clk) begin
      if (reset || err_q) begin
         ext_f <= 1'b0;
         brk_f <= 1'b0;
      end else if (byte_ok) begin
         if (byte_q == CODE_EXT) begin
            ext_f <= 1'b1;
         end else if (byte_q == CODE_BRK) begin
            brk_f <= 1'b1;
         end else begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
         end
      end
   end

   assign valid = (count != '0);
   assign full  = (count == CW'(FIFO_DEPTH));
   assign pop   = rd_en && valid;
   assign wr_ok = push && (!full || pop);
   assign drop  = push && full && !pop;
   assign dout  = valid ? mem[rd_ptr] : '0;

   // NOTE: the storage array has no reset; stale entries are never visible
   // because dout is gated by valid and count is reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= push_evt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A drop in the same cycle as a clear wins, so no lost event goes unreported.
   always_ff @(posedge clk) begin
      if (reset)        overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Directed bench for ps2_event_fifo: frames are bit-banged on ps2c/ps2d and the
// resulting key events, error pulses and FIFO flags are compared against hand values.
module tb_ps2_event_fifo;

   localparam int DEPTH = 8;
   localparam int FL    = 4;
   localparam int TO    = 300;
   localparam int HALF  = 20;

   logic       clk = 1'b0;
   logic       reset, ps2d, ps2c, rx_en, rd_en, ovf_clr, rx_en_nb;
   logic [9:0] dout, nb_dout;
   logic       valid, full, overflow, frame_err;
   logic       nb_valid, nb_full, nb_overflow, nb_frame_err;
   logic [3:0] count, nb_count;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int err_cnt  = 0;

   ps2_event_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .KEEP_BREAK(1)) u_dut (
      .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
      .ovf_clr(ovf_clr), .dout(dout), .valid(valid), .full(full), .count(count),
      .overflow(overflow), .frame_err(frame_err));

   ps2_event_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .KEEP_BREAK(0)) u_nb (
      .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en_nb), .rd_en(1'b0),
      .ovf_clr(1'b0), .dout(nb_dout), .valid(nb_valid), .full(nb_full), .count(nb_count),
      .overflow(nb_overflow), .frame_err(nb_frame_err));

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_err) err_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      return {stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   // Drives the first nbits of a frame; returns right after the last ps2c fall.
   task automatic drive_bits(input logic [10:0] f, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         ps2d = f[i];
         repeat (HALF / 2) @(negedge clk);
         if (glitch) begin
            ps2c = 1'b0;
            @(negedge clk);
            ps2c = 1'b1;
         end
         repeat (HALF / 2) @(negedge clk);
         ps2c = 1'b0;
         if (i != nbits - 1) begin
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
         end
      end
   endtask

   task automatic finish_frame();
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
      ps2d = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      drive_bits(make_frame(b, 1'b0, 1'b1), 11, 1'b0);
      finish_frame();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b0; rd_en = 1'b0;
      ovf_clr = 1'b0; rx_en_nb = 1'b0;
      repeat (5) @(negedge clk);
      chk_cnt++;
      if ({dout, valid, full, count, overflow, frame_err} !== 18'd0)
         $display("FAIL reset_outputs: got dout=%h valid=%b full=%b count=%0d ovf=%b ferr=%b want all 0",
                  dout, valid, full, count, overflow, frame_err);
      else pass_cnt++;
      chk_cnt++;
      if ({nb_dout, nb_valid, nb_full, nb_count, nb_overflow, nb_frame_err} !== 18'd0)
         $display("FAIL reset_nb_outputs: got %h want 0",
                  {nb_dout, nb_valid, nb_full, nb_count, nb_overflow, nb_frame_err});
      else pass_cnt++;
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      rx_en = 1'b1;
      drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
      repeat (FL + 3) @(posedge clk);
      #1;
      chk_cnt++;
      if (valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", valid);
      else pass_cnt++;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (valid !== 1'b1) $display("FAIL basic_valid_rise: got %b want 1", valid);
      else pass_cnt++;
      chk_cnt++;
      if (dout !== 10'h01C) $display("FAIL basic_dout: got %h want 01c", dout);
      else pass_cnt++;
      chk_cnt++;
      if (count !== 4'd1) $display("FAIL basic_count: got %0d want 1", count);
      else pass_cnt++;
      @(negedge clk);
      finish_frame();
      pop();
      chk_cnt++;
      if (valid !== 1'b0 || count !== 4'd0)
         $display("FAIL basic_pop: got valid=%b count=%0d want 0/0", valid, count);
      else pass_cnt++;
   endtask

   task automatic test_prefix();
      rx_en_nb = 1'b1;
      send(8'hE0);
      chk_cnt++;
      if (count !== 4'd0) $display("FAIL prefix_e0_alone: got count %0d want 0", count);
      else pass_cnt++;
      send(8'hF0);
      send(8'h75);
      chk_cnt++;
      if (count !== 4'd1) $display("FAIL prefix_count: got %0d want 1", count);
      else pass_cnt++;
      chk_cnt++;
      if (dout !== 10'h375) $display("FAIL prefix_dout: got %h want 375", dout);
      else pass_cnt++;
      chk_cnt++;
      if (nb_count !== 4'd0) $display("FAIL nobreak_count: got %0d want 0", nb_count);
      else pass_cnt++;
      send(8'h16);
      chk_cnt++;
      if (nb_count !== 4'd1 || nb_dout !== 10'h016)
         $display("FAIL nobreak_make: got count=%0d dout=%h want 1/016", nb_count, nb_dout);
      else pass_cnt++;
      chk_cnt++;
      if (count !== 4'd2) $display("FAIL prefix_count2: got %0d want 2", count);
      else pass_cnt++;
      rx_en_nb = 1'b0;
      pop();
      chk_cnt++;
      if (dout !== 10'h016) $display("FAIL prefix_second: got %h want 016", dout);
      else pass_cnt++;
      pop();
      chk_cnt++;
      if (count !== 4'd0) $display("FAIL prefix_drain: got %0d want 0", count);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      int e0;
      e0 = err_cnt;
      send(8'hF0);
      drive_bits(make_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
      finish_frame();
      send(8'hE0);
      drive_bits(make_frame(8'h1C, 1'b0, 1'b0), 11, 1'b0);
      finish_frame();
      chk_cnt++;
      if (err_cnt - e0 !== 2) $display("FAIL err_pulses: got %0d want 2", err_cnt - e0);
      else pass_cnt++;
      chk_cnt++;
      if (count !== 4'd0) $display("FAIL err_count: got %0d want 0", count);
      else pass_cnt++;
      send(8'h32);
      chk_cnt++;
      if (dout !== 10'h032 || count !== 4'd1)
         $display("FAIL err_flags_cleared: got dout=%h count=%0d want 032/1", dout, count);
      else pass_cnt++;
      pop();
   endtask

   task automatic test_timeout();
      int e0, cyc;
      bit seen;
      e0 = err_cnt;
      cyc = 0;
      seen = 1'b0;
      drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 5, 1'b0);
      while (cyc < TO + 100 && !seen) begin
         @(negedge clk);
         cyc++;
         if (cyc == HALF) begin
            ps2c = 1'b1;
            ps2d = 1'b1;
         end
         if (frame_err) seen = 1'b1;
      end
      chk_cnt++;
      if (!seen || cyc < TO || cyc > TO + FL + 6)
         $display("FAIL timeout_pulse: got seen=%b at cycle %0d want pulse in %0d..%0d",
                  seen, cyc, TO, TO + FL + 6);
      else pass_cnt++;
      repeat (HALF) @(negedge clk);
      chk_cnt++;
      if (err_cnt - e0 !== 1) $display("FAIL timeout_single: got %0d pulses want 1", err_cnt - e0);
      else pass_cnt++;
      send(8'h1C);
      chk_cnt++;
      if (dout !== 10'h01C || count !== 4'd1)
         $display("FAIL timeout_recover: got dout=%h count=%0d want 01c/1", dout, count);
      else pass_cnt++;
      pop();
   endtask

   task automatic test_glitch_rx_en();
      int e0;
      e0 = err_cnt;
      rx_en = 1'b0;
      drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b1);
      finish_frame();
      chk_cnt++;
      if (count !== 4'd0) $display("FAIL rx_disabled: got count %0d want 0", count);
      else pass_cnt++;
      rx_en = 1'b1;
      drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b1);
      finish_frame();
      chk_cnt++;
      if (dout !== 10'h01C || count !== 4'd1)
         $display("FAIL glitch_frame: got dout=%h count=%0d want 01c/1", dout, count);
      else pass_cnt++;
      chk_cnt++;
      if (err_cnt !== e0) $display("FAIL glitch_err: got %0d pulses want 0", err_cnt - e0);
      else pass_cnt++;
      pop();
   endtask

   task automatic test_overflow();
      logic [9:0] exp;
      for (int v = 1; v <= DEPTH; v++) send(8'(v));
      chk_cnt++;
      if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0)
         $display("FAIL fill: got count=%0d full=%b ovf=%b want 8/1/0", count, full, overflow);
      else pass_cnt++;
      send(8'h09);
      chk_cnt++;
      if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow);
      else pass_cnt++;
      chk_cnt++;
      if (dout !== 10'h001 || count !== 4'd8 || full !== 1'b1)
         $display("FAIL ovf_head: got dout=%h count=%0d full=%b want 001/8/1", dout, count, full);
      else pass_cnt++;
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk_cnt++;
      if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
      else pass_cnt++;
      drive_bits(make_frame(8'h0A, 1'b0, 1'b1), 11, 1'b0);
      repeat (FL + 3) @(posedge clk);
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk_cnt++;
      if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0)
         $display("FAIL push_pop_full: got count=%0d full=%b ovf=%b want 8/1/0", count, full, overflow);
      else pass_cnt++;
      chk_cnt++;
      if (dout !== 10'h002) $display("FAIL push_pop_head: got %h want 002", dout);
      else pass_cnt++;
      finish_frame();
      for (int i = 0; i < DEPTH; i++) begin
         exp = (i < DEPTH - 1) ? 10'(i + 2) : 10'h00A;
         chk_cnt++;
         if (dout !== exp) $display("FAIL drain_%0d: got %h want %h", i, dout, exp);
         else pass_cnt++;
         pop();
      end
      chk_cnt++;
      if (count !== 4'd0 || valid !== 1'b0)
         $display("FAIL drain_empty: got count=%0d valid=%b want 0/0", count, valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      int e0;
      send(8'h55);
      chk_cnt++;
      if (dout !== 10'h055 || count !== 4'd1)
         $display("FAIL pre_reset: got dout=%h count=%0d want 055/1", dout, count);
      else pass_cnt++;
      drive_bits(make_frame(8'h33, 1'b0, 1'b1), 6, 1'b0);
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
      ps2d = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_cnt++;
      if ({dout, valid, full, count, overflow, frame_err} !== 18'd0)
         $display("FAIL midframe_reset: got dout=%h valid=%b full=%b count=%0d ovf=%b ferr=%b want all 0",
                  dout, valid, full, count, overflow, frame_err);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      e0 = err_cnt;
      repeat (TO + 50) @(negedge clk);
      chk_cnt++;
      if (err_cnt !== e0) $display("FAIL reset_discard: got %0d error pulses want 0", err_cnt - e0);
      else pass_cnt++;
      send(8'h1C);
      chk_cnt++;
      if (dout !== 10'h01C || count !== 4'd1)
         $display("FAIL post_reset_frame: got dout=%h count=%0d want 01c/1", dout, count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prefix();
      test_errors();
      test_timeout();
      test_glitch_rx_en();
      test_overflow();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
